// File: rtl/sparse_match_sequencer.sv
// sparse_match_sequencer
//   Walks the set bits of a latched match mask, one beat per cycle, and for
//   each match reports the dense lane index plus the compressed-buffer offsets
//   into the weight and activation streams.  An empty match mask still yields
//   exactly one beat (oEmpty=1, oLast=1) so downstream sees one beat per set.
//
// Ports:
//   clock, resetn          single clock, synchronous active-low reset
//   ivalid/iready          input handshake for {bitmaskW, bitmaskA, matchMask}
//   bitmaskW, bitmaskA     weight / activation nonzero masks
//   matchMask              bitmaskW & bitmaskA from the matcher (not re-checked)
//   ovalid/oready          output beat handshake
//   oIndex                 dense lane of the current match
//   oOffsetW, oOffsetA     popcount of the W / A mask below oIndex
//   oLast                  final beat of the current set
//   oEmpty                 current set had no matches
//   oCount                 number of matches in the current set
module sparse_match_sequencer #(
    parameter int unsigned MASK_WIDTH  = 16,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   ivalid,
    output logic                   iready,
    input  logic [MASK_WIDTH-1:0]  bitmaskW,
    input  logic [MASK_WIDTH-1:0]  bitmaskA,
    input  logic [MASK_WIDTH-1:0]  matchMask,
    output logic                   ovalid,
    input  logic                   oready,
    output logic [INDEX_WIDTH-1:0] oIndex,
    output logic [INDEX_WIDTH-1:0] oOffsetW,
    output logic [INDEX_WIDTH-1:0] oOffsetA,
    output logic                   oLast,
    output logic                   oEmpty,
    output logic [INDEX_WIDTH:0]   oCount
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]            state;
    logic [MASK_WIDTH-1:0] reg_w;
    logic [MASK_WIDTH-1:0] reg_a;
    logic [MASK_WIDTH-1:0] remaining;
    logic [INDEX_WIDTH:0]  count_q;
    logic                  empty_q;
    logic                  last_q;

    logic [INDEX_WIDTH-1:0] cur_idx;
    logic                   found;
    logic [MASK_WIDTH-1:0]  low_mask;
    logic [INDEX_WIDTH:0]   pop_w;
    logic [INDEX_WIDTH:0]   pop_a;
    logic                   emit_last;

    function automatic logic [INDEX_WIDTH:0] popcount(input logic [MASK_WIDTH-1:0] v);
        logic [INDEX_WIDTH:0] c;
        c = '0;
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            c = c + (INDEX_WIDTH+1)'(v[i]);
        end
        return c;
    endfunction

    // Lowest set bit of remaining, and a mask of all lanes strictly below it.
    always_comb begin
        cur_idx  = '0;
        found    = 1'b0;
        low_mask = '0;
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (remaining[i] && !found) begin
                cur_idx = INDEX_WIDTH'(i);
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            low_mask[i] = (INDEX_WIDTH'(i) < cur_idx);
        end
        pop_w     = popcount(reg_w & low_mask);
        pop_a     = popcount(reg_a & low_mask);
        // An empty set presents a single beat that is also the last one.
        emit_last = empty_q || (popcount(remaining) == (INDEX_WIDTH+1)'(1));
    end

    assign iready   = resetn && (state == ST_IDLE);
    assign ovalid   = (state == ST_EMIT);
    assign oIndex   = cur_idx;
    assign oOffsetW = pop_w[INDEX_WIDTH-1:0];
    assign oOffsetA = pop_a[INDEX_WIDTH-1:0];
    // In IDLE oLast holds the value of the final beat of the previous set.
    assign oLast    = (state == ST_EMIT) ? emit_last : last_q;
    assign oEmpty   = empty_q;
    assign oCount   = count_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            reg_w     <= '0;
            reg_a     <= '0;
            remaining <= '0;
            count_q   <= '0;
            empty_q   <= 1'b0;
            last_q    <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (ivalid && iready) begin
                reg_w     <= bitmaskW;
                reg_a     <= bitmaskA;
                remaining <= matchMask;
                count_q   <= popcount(matchMask);
                empty_q   <= (matchMask == '0);
                state     <= ST_EMIT;
            end
        end else begin
            if (oready) begin
                remaining <= remaining & (remaining - MASK_WIDTH'(1));
                if (emit_last) begin
                    last_q <= 1'b1;
                    state  <= ST_IDLE;
                end
            end
        end
    end

endmodule
